// File: rtl/abro_event_source.sv
// Stimulus/self-check source for an ABRO machine: emits ordered A/B pulses, then checks O.
// Define ABRO_SRC_AUTORESET_EN to add a 2-cycle dut_rst_no pulse after every response.
module abro_event_source #(
  parameter int unsigned GapW    = 8,
  parameter int unsigned Timeout = 16,
  parameter int unsigned CntW    = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_order_i,
  input  logic [GapW-1:0] cmd_gap_i,
  output logic            a_o,
  output logic            b_o,
  input  logic            o_i,
  output logic            rsp_valid_o,
  output logic            rsp_ok_o,
  output logic            rsp_timeout_o,
  output logic [CntW-1:0] pass_count_o,
  output logic [CntW-1:0] fail_count_o,
`ifdef ABRO_SRC_AUTORESET_EN
  output logic            dut_rst_no,
`endif
  output logic [2:0]      state_o
);

  localparam int unsigned WaitW = $clog2(Timeout);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(Timeout - 1);

  localparam logic [1:0] OrdAB    = 2'd0;
  localparam logic [1:0] OrdBA    = 2'd1;
  localparam logic [1:0] OrdBoth  = 2'd2;
  localparam logic [1:0] OrdAOnly = 2'd3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFirst  = 3'd1,
    StGap    = 3'd2,
    StSecond = 3'd3,
    StWaitO  = 3'd4,
`ifdef ABRO_SRC_AUTORESET_EN
    StResp   = 3'd5,
    StRst    = 3'd6
`else
    StResp   = 3'd5
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        order_q, order_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              ok_q, ok_d;
  logic              to_q, to_d;
  logic [CntW-1:0]   pass_q, pass_d;
  logic [CntW-1:0]   fail_q, fail_d;

  always_comb begin
    state_d     = state_q;
    order_d     = order_q;
    gap_d       = gap_q;
    wait_cnt_d  = '0;
    ok_d        = ok_q;
    to_d        = to_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    a_o         = 1'b0;
    b_o         = 1'b0;
    rsp_valid_o = 1'b0;
    cmd_ready_o = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready_o = rst_ni;
        if (cmd_valid_i && cmd_ready_o) begin
          order_d = cmd_order_i;
          gap_d   = cmd_gap_i;
          state_d = StFirst;
        end
      end
      // O here may belong to the previous command, so it is not sampled.
      StFirst: begin
        a_o = (order_q != OrdBA);
        b_o = (order_q == OrdBA) || (order_q == OrdBoth);
        if (order_q[1])          state_d = StWaitO;
        else if (gap_q != '0)    state_d = StGap;
        else                     state_d = StSecond;
      end
      // gap_q doubles as the down-counter for the idle spacing.
      StGap: begin
        if (o_i) begin
          ok_d    = 1'b0;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (gap_q == GapW'(1)) begin
          state_d = StSecond;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StSecond: begin
        a_o = (order_q == OrdBA);
        b_o = (order_q == OrdAB);
        if (o_i) begin
          ok_d    = 1'b0;
          to_d    = 1'b0;
          state_d = StResp;
        end else begin
          state_d = StWaitO;
        end
      end
      StWaitO: begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (o_i) begin
          ok_d    = (order_q != OrdAOnly);
          to_d    = 1'b0;
          state_d = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          ok_d    = (order_q == OrdAOnly);
          to_d    = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        if (ok_q) begin
          if (pass_q != '1) pass_d = pass_q + CntW'(1);
        end else begin
          if (fail_q != '1) fail_d = fail_q + CntW'(1);
        end
`ifdef ABRO_SRC_AUTORESET_EN
        state_d = StRst;
`else
        state_d = StIdle;
`endif
      end
`ifdef ABRO_SRC_AUTORESET_EN
      StRst: begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (wait_cnt_q[0]) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      order_q    <= '0;
      gap_q      <= '0;
      wait_cnt_q <= '0;
      ok_q       <= 1'b0;
      to_q       <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      gap_q      <= gap_d;
      wait_cnt_q <= wait_cnt_d;
      ok_q       <= ok_d;
      to_q       <= to_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign rsp_ok_o      = ok_q;
  assign rsp_timeout_o = to_q;
  assign pass_count_o  = pass_q;
  assign fail_count_o  = fail_q;
  assign state_o       = state_q;
`ifdef ABRO_SRC_AUTORESET_EN
  assign dut_rst_no    = (state_q != StRst);
`endif

endmodule

// File: tb/tb_abro_event_source.sv
// Bench for abro_event_source: directed and random commands against a cycle-index model.
module tb_abro_event_source;

  localparam int Timeout = 16;
  localparam int CntMax  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_order = 2'd0;
  logic [7:0] cmd_gap = 8'd0;
  logic       a, b;
  logic       o = 1'b0;
  logic       rsp_valid, rsp_ok, rsp_timeout;
  logic [7:0] pass_count, fail_count;
  logic [2:0] state;
`ifdef ABRO_SRC_AUTORESET_EN
  logic       dut_rst_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pass_m   = 0;
  int fail_m   = 0;

  always #5 clk = ~clk;

  abro_event_source #(
    .GapW    (8),
    .Timeout (Timeout),
    .CntW    (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_order_i   (cmd_order),
    .cmd_gap_i     (cmd_gap),
    .a_o           (a),
    .b_o           (b),
    .o_i           (o),
    .rsp_valid_o   (rsp_valid),
    .rsp_ok_o      (rsp_ok),
    .rsp_timeout_o (rsp_timeout),
    .pass_count_o  (pass_count),
    .fail_count_o  (fail_count),
`ifdef ABRO_SRC_AUTORESET_EN
    .dut_rst_no    (dut_rst_n),
`endif
    .state_o       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k = cycle (1 = first cycle after acceptance) in which O is pulsed; 0 = never.
  task automatic run_cmd(input int ord, input int gap, input int k);
    int ws, resp, exp_ok, exp_to;
    logic ea, eb, first, second;
    ws = (ord < 2) ? 3 + gap : 2;
    if (ord < 2 && k >= 2 && k <= 2 + gap) begin
      resp = k + 1; exp_ok = 0; exp_to = 0;
    end else if (k >= ws && k <= ws + Timeout - 1) begin
      resp = k + 1; exp_ok = (ord != 3); exp_to = 0;
    end else begin
      resp = ws + Timeout; exp_ok = (ord == 3); exp_to = 1;
    end
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
`ifdef ABRO_SRC_AUTORESET_EN
    check("dut_rst_idle", dut_rst_n, 1);
`endif
    cmd_valid = 1'b1;
    cmd_order = 2'(ord);
    cmd_gap   = 8'(gap);
    o         = 1'b0;
    for (int n = 1; n <= resp; n++) begin
      @(negedge clk);
      // Junk commands while busy must be ignored.
      cmd_valid = (n < resp) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_order = 2'($urandom);
      cmd_gap   = 8'($urandom);
      first  = (n == 1);
      second = (ord < 2) && (n == 2 + gap) && (n < resp);
      ea = (first && ord != 1) || (second && ord == 1);
      eb = (first && (ord == 1 || ord == 2)) || (second && ord == 0);
      check("pulse_a", a, ea);
      check("pulse_b", b, eb);
      check("rsp_valid", rsp_valid, (n == resp));
      check("ready_busy", cmd_ready, 0);
      if (n == resp) begin
        check("rsp_ok", rsp_ok, exp_ok);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("state_resp", state, 5);
      end
      o = (n == k);
    end
    if (exp_ok != 0) pass_m = (pass_m < CntMax) ? pass_m + 1 : CntMax;
    else             fail_m = (fail_m < CntMax) ? fail_m + 1 : CntMax;
    @(negedge clk);
    o = 1'b0;
    check("pass_count", pass_count, pass_m);
    check("fail_count", fail_count, fail_m);
    check("rsp_valid_after", rsp_valid, 0);
`ifdef ABRO_SRC_AUTORESET_EN
    check("dut_rst_lo1", dut_rst_n, 0);
    check("ready_rst1", cmd_ready, 0);
    @(negedge clk);
    check("dut_rst_lo2", dut_rst_n, 0);
    check("ready_rst2", cmd_ready, 0);
`endif
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("ready_in_reset", cmd_ready, 0);
    check("state_reset", state, 0);
    check("a_reset", a, 0);
    check("b_reset", b, 0);
    check("rsp_valid_reset", rsp_valid, 0);
    check("rsp_ok_reset", rsp_ok, 0);
    check("rsp_to_reset", rsp_timeout, 0);
    check("pass_reset", pass_count, 0);
    check("fail_reset", fail_count, 0);
    rst_n = 1'b1;

    // Directed cases
    run_cmd(0, 3, 7);             // A@1, B@5, O two cycles after B
    run_cmd(2, 7, 2);             // A and B together, gap ignored
    run_cmd(3, 0, 0);             // A only, timeout is the pass condition
    run_cmd(1, 2, 0);             // B then A, no O: timeout fail
    run_cmd(1, 2, 3);             // O during GAP: premature fail
    run_cmd(0, 0, 2);             // O in SECOND with zero gap: premature
    run_cmd(2, 0, 1 + Timeout);   // O on the timeout cycle wins
    run_cmd(0, 1, 1);             // O in FIRST ignored, then timeout
    run_cmd(3, 0, 5);             // O for A-only is a failure

    // Reset mid-command during GAP
    @(negedge clk);
    cmd_valid = 1'b1; cmd_order = 2'd0; cmd_gap = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_first_a", a, 1);
    @(negedge clk);
    check("mid_state_gap", state, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", state, 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_b", b, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_pass", pass_count, 0);
    check("mid_rst_fail", fail_count, 0);
    check("mid_rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    pass_m = 0;
    fail_m = 0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_rsp", rsp_valid, 0);
    check("post_rst_state", state, 0);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      int ord, gap, k;
      ord = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 5));
      k   = int'($urandom_range(0, gap + Timeout + 5));
      run_cmd(ord, gap, k);
    end

    // Saturation of the pass counter
    for (int i = 0; i < 260; i++) run_cmd(2, 0, 2);
    check("pass_saturated", pass_count, CntMax);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/abro_event_source.md
Name: abro_event_source

Overview:
- Initiator counterpart to the ABRO state machine: emits the A/B event pulses the ABRO machine consumes, and checks the O pulse it returns.
- Accepts one command at a time over a valid/ready handshake.
- Drives single-cycle A/B pulses in a commanded order and spacing, then waits for O with a bounded timeout.
- Reports a per-command pass/fail response and keeps running pass/fail counts; used as an on-chip stimulus and self-check source.

Parameters:
- GAP_W, 8, width of cmd_gap (cycles inserted between first and second pulse).
- TIMEOUT, 16, cycles spent in WAIT_O before declaring a timeout; legal minimum is 2.
- CNT_W, 8, width of the pass/fail counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  source can accept a command; high only in IDLE.
- cmd_order  in  2  00 = A then B; 01 = B then A; 10 = A and B in the same cycle; 11 = A only (negative case, no O expected).
- cmd_gap  in  GAP_W  idle cycles between first and second pulse; used for orders 00/01 only.
- A  out  1  event A pulse to the ABRO machine.
- B  out  1  event B pulse to the ABRO machine.
- O  in  1  output returned by the ABRO machine.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_ok  out  1  command passed; valid with rsp_valid.
- rsp_timeout  out  1  WAIT_O expired without O; valid with rsp_valid.
- pass_count  out  CNT_W  saturating count of passed commands.
- fail_count  out  CNT_W  saturating count of failed commands.
- state  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FIRST=1, GAP=2, SECOND=3, WAIT_O=4, RESP=5. Codes 6 and 7 recover to IDLE.
- Reset (resetn=0 at a clock edge):
  - state=IDLE; A=B=0; rsp_valid=rsp_ok=rsp_timeout=0; pass_count=fail_count=0; all internal counters 0.
  - cmd_ready=0 while resetn is low, and 1 on the first cycle after release.
  - Reset mid-operation aborts the command with no response and no counter update.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_order and cmd_gap and move to FIRST. The handshake costs one cycle, so the first pulse appears on the cycle after acceptance.
- FIRST (exactly 1 cycle):
  - A=1 for order 00/10/11.
  - B=1 for order 01/10.
  - Next state: orders 10/11 go to WAIT_O; orders 00/01 go to GAP if gap>0, otherwise SECOND.
- GAP: lasts exactly cmd_gap cycles with A=B=0, then SECOND.
- SECOND (exactly 1 cycle): B=1 for order 00; A=1 for order 01. Next state WAIT_O.
- A and B are never high outside FIRST and SECOND. Each pulse is exactly one cycle wide.
- Premature O: O=1 sampled in GAP or SECOND moves to RESP with ok=0 and timeout=0.
- O sampled in FIRST is ignored, since it may be the response to a previous command.
- WAIT_O:
  - Cycle counter starts at 0 on entry.
  - O=1 moves to RESP with timeout=0 and ok=1, except order 11 gives ok=0.
  - If the counter reaches TIMEOUT-1 with O=0, move to RESP with timeout=1; ok=1 only for order 11.
  - O and timeout on the same cycle: O wins.
- RESP (1 cycle): rsp_valid=1; rsp_ok and rsp_timeout hold the recorded result.
  - The edge leaving RESP increments pass_count if ok, otherwise fail_count. The new count is visible the cycle after rsp_valid.
  - Counters saturate at all-ones with no wrap.
  - Next state IDLE. rsp_ok and rsp_timeout hold their value until the next RESP.
- Command-to-response latency, in cycles from acceptance edge to rsp_valid:
  - Orders 00/01: 3 + gap + w.
  - Orders 10/11: 2 + w.
  - Here w is the number of WAIT_O cycles, from 1 to TIMEOUT.
- cmd_valid outside IDLE is ignored; the command is not latched.

Optional Feature:
- ABRO_SRC_AUTORESET_EN defined:
  - Adds output port dut_rst_n (1 bit, reset value 1) and a state RST=6.
  - RESP goes to RST; RST drives dut_rst_n=0 for exactly 2 cycles, then goes to IDLE.
  - cmd_ready stays 0 during RST.
  - Latency to the next cmd_ready grows by 2 cycles.
- Undefined: no dut_rst_n port and no RST state; RESP goes directly to IDLE, and code 6 recovers to IDLE.

Test Plan:
- Order 00, gap 3, model asserts O 2 cycles after the B pulse → A high on cycle 1 after acceptance, B high on cycle 5, rsp_valid with rsp_ok=1 and rsp_timeout=0; pass_count=1 on the following cycle.
- Order 10 with cmd_gap=7 (ignored) → A and B high together for exactly one cycle; O returned → rsp_ok=1, pass_count increments.
- Order 11, O held at 0 → rsp_valid 16 cycles after entering WAIT_O with rsp_timeout=1 and rsp_ok=1; pass_count increments.
- Order 01, gap 2, O never asserted → rsp_timeout=1, rsp_ok=0, fail_count=1. Second case: O forced high during GAP → immediate RESP with rsp_ok=0, rsp_timeout=0, fail_count=2.
- resetn low for one cycle during GAP → next cycle state=0, A=B=0, both counters 0, no rsp_valid; cmd_ready=1 after release.
- With ABRO_SRC_AUTORESET_EN, run 256 passing commands at CNT_W=8 → pass_count saturates at 255; dut_rst_n is low for 2 cycles after every rsp_valid.
